spi_reg_bank: RTL and testbench

Parametrised SPI-slave register bank that connects the Raspberry Pi host to the FPGA's control and status registers. It sits behind the decoded FPGA chip select, next to the audio, SRAM and MPIO blocks. The bank supports configurable output and input register counts, burst auto-increment addressing, per-register write strobes and read strobes. SPI pins are oversampled in the system clock domain, so the block uses a single clock.

---
 rtl/spi_reg_bank.sv | 199 +++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// SPI-slave (mode 0) control/status register bank, oversampled in the clk domain.
// Define SPI_BURST_EN for unlimited auto-increment bursts; otherwise one data byte per frame.
module spi_reg_bank #(
    parameter int unsigned NUM_OUT_REGS = 8,
    parameter int unsigned NUM_IN_REGS  = 4,
    parameter logic [8*NUM_OUT_REGS-1:0] OUT_RESET = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      spi_cs_n,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    output logic                      spi_miso_oe,
    input  logic [8*NUM_IN_REGS-1:0]  in_regs,
    output logic [8*NUM_OUT_REGS-1:0] out_regs,
    output logic [NUM_OUT_REGS-1:0]   wr_stb,
    output logic [NUM_IN_REGS-1:0]    rd_stb,
    output logic                      frame_active
);

    localparam int unsigned TOTAL_REGS = NUM_OUT_REGS + NUM_IN_REGS;
    localparam logic [6:0]  LAST_ADDR  = 7'(TOTAL_REGS - 1);

`ifdef SPI_BURST_EN
    localparam logic BURST = 1'b1;
`else
    localparam logic BURST = 1'b0;
`endif

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CMD    = 2'd1;
    localparam logic [1:0] DATA   = 2'd2;
    localparam logic [1:0] IGNORE = 2'd3;

    logic [1:0] state;
    logic [1:0] state_next;

    logic [2:0] cs_sync;
    logic [2:0] sclk_sync;
    logic [1:0] mosi_sync;

    logic       cs_fall;
    logic       cs_rise;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       mosi_bit;
    logic       byte_end;

    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;
    logic [7:0] byte_val;
    logic       byte_done;
    logic       done_cmd;
    logic       rw;
    logic [6:0] addr;
    logic [6:0] addr_next;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;

    // cs sync flops reset to "asserted" so a low cs at reset release does not look like a new frame
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
        end else begin
            cs_sync   <= {cs_sync[1:0], spi_cs_n};
            sclk_sync <= {sclk_sync[1:0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    assign cs_fall   = cs_sync[2] & ~cs_sync[1];
    assign cs_rise   = ~cs_sync[2] & cs_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign mosi_bit  = mosi_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; a cs rise overrides any byte completing in the same cycle
    always_comb begin
        state_next = state;
        byte_end   = 1'b0;
        if (sclk_rise && (bit_cnt == 3'd7) && !cs_rise &&
            ((state == CMD) || (state == DATA))) begin
            byte_end = 1'b1;
        end
        if (cs_rise) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall) state_next = CMD;
                CMD:     if (byte_end) state_next = DATA;
                DATA:    if (byte_end && !BURST) state_next = IGNORE;
                IGNORE:  state_next = IGNORE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Address sequencing and readback mux
    always_comb begin
        addr_next = (addr == LAST_ADDR) ? 7'd0 : addr + 7'd1;
        rd_addr   = done_cmd ? addr : addr_next;
        rd_data   = 8'h00;
        for (int unsigned k = 0; k < NUM_OUT_REGS; k++) begin
            if (rd_addr == 7'(k)) rd_data = out_regs[8*k +: 8];
        end
        for (int unsigned j = 0; j < NUM_IN_REGS; j++) begin
            if (rd_addr == 7'(NUM_OUT_REGS + j)) rd_data = in_regs[8*j +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt      <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            byte_val     <= '0;
            byte_done    <= 1'b0;
            done_cmd     <= 1'b0;
            rw           <= 1'b0;
            addr         <= '0;
            out_regs     <= OUT_RESET;
            wr_stb       <= '0;
            rd_stb       <= '0;
            spi_miso     <= 1'b0;
            spi_miso_oe  <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            wr_stb    <= '0;
            rd_stb    <= '0;
            byte_done <= 1'b0;
            if (cs_rise) begin
                frame_active <= 1'b0;
                spi_miso_oe  <= 1'b0;
                spi_miso     <= 1'b0;
                tx_sr        <= '0;
            end else if (state == IDLE) begin
                if (cs_fall) begin
                    frame_active <= 1'b1;
                    spi_miso_oe  <= 1'b1;
                    spi_miso     <= 1'b0;
                    tx_sr        <= '0;
                    bit_cnt      <= '0;
                end
            end else begin
                if (sclk_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx_sr   <= {rx_sr[5:0], mosi_bit};
                end
                if (byte_end) begin
                    byte_val  <= {rx_sr, mosi_bit};
                    byte_done <= 1'b1;
                    done_cmd  <= (state == CMD);
                    if (state == CMD) begin
                        rw   <= rx_sr[6];
                        addr <= {rx_sr[5:0], mosi_bit};
                    end
                end
                if (sclk_fall) begin
                    spi_miso <= tx_sr[7];
                    tx_sr    <= {tx_sr[6:0], 1'b0};
                end
                // Act on the byte captured one cycle earlier
                if (byte_done) begin
                    if (!done_cmd) addr <= addr_next;
                    if (!rw && !done_cmd) begin
                        for (int unsigned k = 0; k < NUM_OUT_REGS; k++) begin
                            if (addr == 7'(k)) begin
                                out_regs[8*k +: 8] <= byte_val;
                                wr_stb[k]          <= 1'b1;
                            end
                        end
                    end
                    if (rw && (done_cmd || BURST)) begin
                        tx_sr <= rd_data;
                        for (int unsigned j = 0; j < NUM_IN_REGS; j++) begin
                            if (rd_addr == 7'(NUM_OUT_REGS + j)) rd_stb[j] <= 1'b1;
                        end
                    end else if (!done_cmd && !BURST) begin
                        tx_sr    <= '0;
                        spi_miso <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: bit-banged SPI frames, MISO scoreboard and strobe counters.
module tb_spi_reg_bank;

    localparam int unsigned NOUT  = 8;
    localparam int unsigned NIN   = 4;
    localparam int unsigned TOTAL = NOUT + NIN;
    localparam int          HALF  = 6;
    localparam logic [63:0] RST_VAL = 64'h8877_6655_4433_2211;

`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_cs_n;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [31:0] in_regs;
    logic [63:0] out_regs;
    logic [7:0]  wr_stb;
    logic [3:0]  rd_stb;
    logic        frame_active;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_reg_bank #(
        .NUM_OUT_REGS (NOUT),
        .NUM_IN_REGS  (NIN),
        .OUT_RESET    (RST_VAL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spi_cs_n     (spi_cs_n),
        .spi_clk      (spi_clk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .in_regs      (in_regs),
        .out_regs     (out_regs),
        .wr_stb       (wr_stb),
        .rd_stb       (rd_stb),
        .frame_active (frame_active)
    );

    // Strobe monitor: counts high cycles per strobe bit
    int          wr_cnt [NOUT] = '{default: 0};
    int          rd_cnt [NIN]  = '{default: 0};
    logic [7:0]  wr_last = 8'h00;
    time         wr_time = 0;

    always @(negedge clk) begin
        for (int k = 0; k < int'(NOUT); k++) if (wr_stb[k] === 1'b1) wr_cnt[k]++;
        for (int j = 0; j < int'(NIN); j++) if (rd_stb[j] === 1'b1) rd_cnt[j]++;
        if (|wr_stb) begin
            wr_last = wr_stb;
            wr_time = $time;
        end
    end

    // Reference model state
    logic [63:0] exp_out;
    int          exp_wr [NOUT] = '{default: 0};
    int          exp_rd [NIN]  = '{default: 0};
    logic [7:0]  sb [$];
    logic [7:0]  wdata [4];
    time         last_rise = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] mread(input logic [6:0] a);
        int ai = int'(a);
        if (ai < int'(NOUT)) return exp_out[8*ai +: 8];
        if (ai < int'(TOTAL)) return in_regs[8*(ai-int'(NOUT)) +: 8];
        return 8'h00;
    endfunction

    function automatic logic [6:0] anext(input logic [6:0] a);
        return (a == 7'(TOTAL - 1)) ? 7'd0 : a + 7'd1;
    endfunction

    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[7-i];
            repeat (HALF) @(negedge clk);
            mi = {mi[6:0], spi_miso};
            spi_clk   = 1'b1;
            last_rise = $time;
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    // Full frame: model pushes expected MISO bytes, stimulus pops and compares
    task automatic frame(input logic [7:0] cmd, input int nbytes);
        logic [6:0] a;
        logic [7:0] rb;
        logic [7:0] expb;
        int         ai;
        sb.push_back(8'h00);
        a = cmd[6:0];
        if (cmd[7]) begin
            for (int j = 0; j <= nbytes; j++) begin
                ai = int'(a);
                if (j == 0 || BURST) begin
                    if (j < nbytes) sb.push_back(mread(a));
                    if (ai >= int'(NOUT) && ai < int'(TOTAL)) exp_rd[ai-int'(NOUT)]++;
                end else if (j < nbytes) begin
                    sb.push_back(8'h00);
                end
                a = anext(a);
            end
        end else begin
            for (int j = 0; j < nbytes; j++) begin
                ai = int'(a);
                sb.push_back(8'h00);
                if ((j == 0 || BURST) && ai < int'(NOUT)) begin
                    exp_out[8*ai +: 8] = wdata[j];
                    exp_wr[ai]++;
                end
                a = anext(a);
            end
        end
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        xfer(cmd, 8, rb);
        expb = sb.pop_front();
        chk("miso_cmd", 64'(rb), 64'(expb));
        chk("frame_active_mid", 64'(frame_active), 64'd1);
        chk("miso_oe_mid", 64'(spi_miso_oe), 64'd1);
        for (int j = 0; j < nbytes; j++) begin
            xfer(wdata[j], 8, rb);
            expb = sb.pop_front();
            chk("miso_data", 64'(rb), 64'(expb));
        end
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2*HALF) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_out_regs"}, out_regs, exp_out);
        for (int k = 0; k < int'(NOUT); k++) chk({tag, "_wr_cnt"}, 64'(wr_cnt[k]), 64'(exp_wr[k]));
        for (int j = 0; j < int'(NIN); j++) chk({tag, "_rd_cnt"}, 64'(rd_cnt[j]), 64'(exp_rd[j]));
    endtask

    initial begin
        logic [7:0] rb;
        reset    = 1'b1;
        spi_cs_n = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        in_regs  = 32'hD3C2_B1A0;
        exp_out  = RST_VAL;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_regs", out_regs, RST_VAL);
        chk("rst_wr_stb", 64'(wr_stb), 64'd0);
        chk("rst_rd_stb", 64'(rd_stb), 64'd0);
        chk("rst_miso", 64'(spi_miso), 64'd0);
        chk("rst_miso_oe", 64'(spi_miso_oe), 64'd0);
        chk("rst_frame_active", 64'(frame_active), 64'd0);
        repeat (8) @(negedge clk);

        // Single write with strobe timing
        wdata[0] = 8'hA5;
        frame(8'h03, 1);
        chk("wr_stb_value", 64'(wr_last), 64'h08);
        chk("wr_latency", 64'(wr_time - last_rise), 64'd40);
        check_state("single_write");

        // Read across the wrap point
        frame(8'h8A, 4);
        check_state("burst_read");

        // Abort after 5 data bits
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        xfer(8'h01, 8, rb);
        chk("abort_cmd_miso", 64'(rb), 64'd0);
        xfer(8'hFF, 5, rb);
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_fa_before", 64'(frame_active), 64'd1);
        @(negedge clk);
        chk("abort_fa_after", 64'(frame_active), 64'd0);
        chk("abort_oe_after", 64'(spi_miso_oe), 64'd0);
        repeat (2*HALF) @(negedge clk);
        check_state("abort");

        // Out-of-range write, read-only write, out-of-range read
        wdata[0] = 8'h55;
        frame(8'h0C, 1);
        wdata[0] = 8'h77;
        frame(8'h09, 1);
        frame(8'hFF, 1);
        check_state("out_of_range");

        // Multi-byte write: burst writes all, single-byte mode only register 0
        wdata[0] = 8'h11;
        wdata[1] = 8'h22;
        wdata[2] = 8'h33;
        frame(8'h00, 3);
        check_state("multi_write");

        // Reset mid-frame with cs held low
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        xfer(8'h02, 8, rb);
        xfer(8'hF0, 4, rb);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        exp_out = RST_VAL;
        @(negedge clk);
        chk("midrst_out_regs", out_regs, RST_VAL);
        chk("midrst_fa", 64'(frame_active), 64'd0);
        chk("midrst_oe", 64'(spi_miso_oe), 64'd0);
        xfer(8'h05, 8, rb);
        xfer(8'hEE, 8, rb);
        chk("midrst_miso", 64'(rb), 64'd0);
        chk("midrst_fa_held", 64'(frame_active), 64'd0);
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2*HALF) @(negedge clk);
        check_state("mid_reset");

        // Recovery on a fresh frame
        wdata[0] = 8'h3C;
        frame(8'h06, 1);
        frame(8'h86, 1);
        check_state("recovery");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
